// File: rtl/cnn_conv_3x3_lane_sched.sv
// cnn_conv_3x3_lane_sched
// Front-end sequencer for the 8-lane 3x3 convolution block. It accepts one
// weight stream and one channel-interleaved pixel stream, registers each
// accepted word and marks the lane that owns its input channel with a one-hot
// select. It also runs frame control: weight load, pixel stream, then drain
// until the last adder-tree result has been counted.
module cnn_conv_3x3_lane_sched #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 612,
    parameter int IMAGE_HEIGHT    = 612,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 64,
    parameter int KERNEL          = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stride2_cfg,
    input  logic                  valid_weight_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic                  weight_ready,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  pxl_ready,
    input  logic                  res_valid,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic [7:0]            valid_weight_out,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic [7:0]            valid_pxl_out,
    output logic                  stride2,
    output logic                  busy,
    output logic                  done
);

    // Each of the eight lanes owns a contiguous block of LANE_CH input channels.
    localparam int LANE_CH = CHANNEL_NUM_IN / 8;
    localparam int KK      = KERNEL * KERNEL;
    localparam int P_TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM_IN;
    localparam int R_FULL  = CHANNEL_NUM_OUT * IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int R_HALF  = CHANNEL_NUM_OUT * (IMAGE_WIDTH / 2) * (IMAGE_HEIGHT / 2);

    localparam int TAP_W = $clog2(KK + 1);
    localparam int SUB_W = $clog2(LANE_CH + 1);
    localparam int OCH_W = $clog2(CHANNEL_NUM_OUT + 1);
    localparam int P_W   = $clog2(P_TOTAL + 1);
    localparam int R_W   = $clog2(R_FULL + 1);

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(KK - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(LANE_CH - 1);
    localparam logic [OCH_W-1:0] OCH_LAST = OCH_W'(CHANNEL_NUM_OUT - 1);
    localparam logic [P_W-1:0]   PCNT_LAST = P_W'(P_TOTAL - 1);
    localparam logic [2:0]       LANE_LAST = 3'd7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD_W = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    logic [1:0]       state;

    // Weight position: tap within kernel, channel within lane, lane, output channel.
    // The input channel index is carried as (w_lane, w_sub) so the lane needs no divider.
    logic [TAP_W-1:0] tap;
    logic [SUB_W-1:0] w_sub;
    logic [2:0]       w_lane;
    logic [OCH_W-1:0] och;

    // Pixel position: channel within lane, lane, and total accepted pixel words.
    logic [SUB_W-1:0] p_sub;
    logic [2:0]       p_lane;
    logic [P_W-1:0]   pcnt;

    // Adder-tree results seen this frame, saturating at the frame's target.
    logic [R_W-1:0]   rcnt;
    logic [R_W-1:0]   r_target;

    logic frame_start;
    logic w_xfer;
    logic p_xfer;
    logic res_hit;
    logic w_last;
    logic p_last;
    logic r_reached;

    assign weight_ready = (state == ST_LOAD_W);
    assign pxl_ready    = (state == ST_STREAM);
    assign busy         = (state != ST_IDLE);

    assign frame_start = (state == ST_IDLE) && start;
    assign w_xfer      = valid_weight_in && weight_ready;
    assign p_xfer      = valid_in && pxl_ready;
    assign res_hit     = res_valid && (state != ST_IDLE);

    assign w_last = w_xfer && (tap == TAP_LAST) && (w_sub == SUB_LAST)
                    && (w_lane == LANE_LAST) && (och == OCH_LAST);
    assign p_last = p_xfer && (pcnt == PCNT_LAST);

    assign r_target  = stride2 ? R_W'(R_HALF) : R_W'(R_FULL);
    assign r_reached = (rcnt == r_target)
                       || (res_valid && (rcnt == (r_target - R_W'(1))));

    // Frame-level FSM: IDLE -> LOAD_W -> STREAM -> DRAIN -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start)     state <= ST_LOAD_W;
                ST_LOAD_W: if (w_last)    state <= ST_STREAM;
                ST_STREAM: if (p_last)    state <= ST_DRAIN;
                ST_DRAIN:  if (r_reached) state <= ST_IDLE;
                default:                  state <= ST_IDLE;
            endcase
        end
    end

    // Stride mode is captured once per frame and held until the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            stride2 <= 1'b0;
        end else if (frame_start) begin
            stride2 <= stride2_cfg;
        end
    end

    // Done pulses for exactly the cycle following the DRAIN exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= (state == ST_DRAIN) && r_reached;
        end
    end

    // Weight position counters: tap fastest, then input channel, then output channel.
    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            tap    <= '0;
            w_sub  <= '0;
            w_lane <= '0;
            och    <= '0;
        end else if (w_xfer) begin
            if (tap == TAP_LAST) begin
                tap <= '0;
                if (w_sub == SUB_LAST) begin
                    w_sub <= '0;
                    if (w_lane == LANE_LAST) begin
                        w_lane <= '0;
                        och    <= (och == OCH_LAST) ? '0 : och + OCH_W'(1);
                    end else begin
                        w_lane <= w_lane + 3'd1;
                    end
                end else begin
                    w_sub <= w_sub + SUB_W'(1);
                end
            end else begin
                tap <= tap + TAP_W'(1);
            end
        end
    end

    // Pixel counters: the channel position wraps every CHANNEL_NUM_IN words.
    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            p_sub  <= '0;
            p_lane <= '0;
            pcnt   <= '0;
        end else if (p_xfer) begin
            pcnt <= pcnt + P_W'(1);
            if (p_sub == SUB_LAST) begin
                p_sub  <= '0;
                p_lane <= (p_lane == LANE_LAST) ? 3'd0 : p_lane + 3'd1;
            end else begin
                p_sub <= p_sub + SUB_W'(1);
            end
        end
    end

    // Result counter: counts in any busy state and stops at the target so that
    // early results during STREAM cannot overflow it.
    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            rcnt <= '0;
        end else if (res_hit && (rcnt != r_target)) begin
            rcnt <= rcnt + R_W'(1);
        end
    end

    // Weight output register: data holds, the lane select is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            weight_out       <= '0;
            valid_weight_out <= '0;
        end else if (w_xfer) begin
            weight_out       <= weight_in;
            valid_weight_out <= 8'b1 << w_lane;
        end else begin
            valid_weight_out <= '0;
        end
    end

    // Pixel output register: data holds, the lane select is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            pxl_out       <= '0;
            valid_pxl_out <= '0;
        end else if (p_xfer) begin
            pxl_out       <= pxl_in;
            valid_pxl_out <= 8'b1 << p_lane;
        end else begin
            valid_pxl_out <= '0;
        end
    end

endmodule
